// File: rtl/simon_pkg.sv
// simon_pkg: shared state encoding, LED constants and helpers for the Simon I/O arbiter
package simon_pkg;
  typedef enum logic [2:0] {S_SIMON, S_ARM, S_READY, S_ECHO, S_OVER} state_t;
  localparam logic [3:0] LED_ALL = 4'b1111;
  function automatic logic [3:0] onehot4(input logic [1:0] idx);
    return 4'b0001 << idx;
  endfunction
endpackage

// File: rtl/simon_debounce.sv
// simon_debounce: 2-FF synchroniser plus stability counter for one raw button
module simon_debounce #(
  parameter int DEBOUNCE_TICKS = 3
) (
  input  logic clk,
  input  logic reset,
  input  logic btn,
  output logic level
);
  localparam int CW = $clog2(DEBOUNCE_TICKS + 1);
  logic syncA, syncB;
  logic [CW-1:0] cnt;
  // synchronise, then flip the level only after DEBOUNCE_TICKS differing samples in a row
  always_ff @(posedge clk) begin
    if (reset) begin
      syncA <= 1'b0;
      syncB <= 1'b0;
      cnt   <= '0;
      level <= 1'b0;
    end else begin
      syncA <= btn;
      syncB <= syncA;
      if (syncB == level) cnt <= '0;
      else if (cnt == CW'(DEBOUNCE_TICKS - 1)) begin
        level <= syncB;
        cnt   <= '0;
      end else cnt <= cnt + 1'b1;
    end
  end
endmodule

// File: rtl/simon_io_arbiter.sv
// simon_io_arbiter: shares the LED/tone panel between the Simon core and the player (SIMON_IO_OVER_FLASH_EN blinks game-over)
module simon_io_arbiter
  import simon_pkg::*;
#(
  parameter int DEBOUNCE_TICKS = 3,
  parameter int ECHO_TICKS     = 15,
  parameter int FLASH_TICKS    = 20
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] btn,
  input  logic       simon_turn,
  input  logic [1:0] simon_num,
  input  logic       simon_pressed,
  input  logic       game_over,
  output logic [1:0] player_num,
  output logic       player_pressed,
  output logic [3:0] led,
  output logic       tone_en,
  output logic [1:0] tone_sel,
  output logic       owner
);
  localparam int EW = $clog2(ECHO_TICKS);
  state_t state, nextState;
  logic [3:0] btnDb, prevDb, overLed;
  logic [1:0] colour, pressIdx;
  logic [EW-1:0] echoCnt;
  logic validPress, simonLit;

  for (genvar i = 0; i < 4; i++) begin : g_db
    simon_debounce #(.DEBOUNCE_TICKS(DEBOUNCE_TICKS)) u_db (
      .clk(clk), .reset(reset), .btn(btn[i]), .level(btnDb[i])
    );
  end

  assign pressIdx = {btnDb[3] | btnDb[2], btnDb[3] | btnDb[1]};
  assign validPress = state == S_READY && !game_over && !simon_turn && prevDb == 4'd0 &&
                      btnDb != 4'd0 && (btnDb & (btnDb - 4'd1)) == 4'd0;

  // state register
  always_ff @(posedge clk) begin
    if (reset) state <= S_ARM;
    else state <= nextState;
  end

  // next state: game-over is sticky, Simon's turn pre-empts everything else
  always_comb begin
    nextState = state;
    if (game_over || state == S_OVER) nextState = S_OVER;
    else if (simon_turn) nextState = S_SIMON;
    else case (state)
      S_SIMON: nextState = S_ARM;
      S_ARM:   nextState = btnDb == 4'd0 ? S_READY : S_ARM;
      S_READY: nextState = validPress ? S_ECHO : S_READY;
      S_ECHO:  nextState = echoCnt == EW'(ECHO_TICKS - 1) ? S_ARM : S_ECHO;
      default: nextState = state;
    endcase
  end

  // press pulse, latched colour and echo timer
  always_ff @(posedge clk) begin
    if (reset) begin
      prevDb         <= '0;
      player_pressed <= 1'b0;
      player_num     <= '0;
      colour         <= '0;
      echoCnt        <= '0;
    end else begin
      prevDb         <= btnDb;
      player_pressed <= validPress;
      if (validPress) begin
        player_num <= pressIdx;
        colour     <= pressIdx;
      end
      echoCnt <= validPress ? '0 : state == S_ECHO ? echoCnt + 1'b1 : echoCnt;
    end
  end

`ifdef SIMON_IO_OVER_FLASH_EN
  localparam int FW = $clog2(FLASH_TICKS);
  logic [FW-1:0] flashCnt;
  logic flashOn;
  // blink timer: primed lit while outside S_OVER so entry starts all-on
  always_ff @(posedge clk) begin
    if (reset) begin
      flashCnt <= '0;
      flashOn  <= 1'b0;
    end else if (state != S_OVER) begin
      flashCnt <= '0;
      flashOn  <= 1'b1;
    end else if (flashCnt == FW'(FLASH_TICKS - 1)) begin
      flashCnt <= '0;
      flashOn  <= ~flashOn;
    end else flashCnt <= flashCnt + 1'b1;
  end
  assign overLed = flashOn ? LED_ALL : 4'b0000;
`else
  assign overLed = LED_ALL;
`endif

  // panel outputs decoded from the current owner state
  always_comb begin
    simonLit = state == S_SIMON && simon_pressed;
    owner    = state == S_SIMON;
    led      = simonLit ? onehot4(simon_num) : state == S_ECHO ? onehot4(colour) :
               state == S_OVER ? overLed : 4'b0000;
    tone_en  = simonLit || state == S_ECHO;
    tone_sel = simonLit ? simon_num : state == S_ECHO ? colour : 2'd0;
  end
endmodule

// File: tb/tb_simon_io_arbiter.sv
// tb_simon_io_arbiter: directed stimulus with a press scoreboard and panel checks
module tb_simon_io_arbiter;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [3:0] btn = '0;
  logic simon_turn = 1'b0;
  logic [1:0] simon_num = '0;
  logic simon_pressed = 1'b0;
  logic game_over = 1'b0;
  logic [1:0] player_num;
  logic player_pressed;
  logic [3:0] led;
  logic tone_en;
  logic [1:0] tone_sel;
  logic owner;
  int nCmp = 0;
  int nBad = 0;
  int expQ[$];
  logic prevPulse = 1'b0;

  simon_io_arbiter dut (
    .clk(clk), .reset(reset), .btn(btn), .simon_turn(simon_turn), .simon_num(simon_num),
    .simon_pressed(simon_pressed), .game_over(game_over), .player_num(player_num),
    .player_pressed(player_pressed), .led(led), .tone_en(tone_en), .tone_sel(tone_sel),
    .owner(owner)
  );

  always #5 clk = ~clk;

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] req);
    nCmp++;
    if (act !== req) begin
      nBad++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  task automatic panel(input string name, input logic [3:0] eLed, input logic eTone,
                       input logic [1:0] eSel, input logic eOwner);
    chk({name, ".led"}, {4'd0, led}, {4'd0, eLed});
    chk({name, ".tone_en"}, {7'd0, tone_en}, {7'd0, eTone});
    chk({name, ".tone_sel"}, {6'd0, tone_sel}, {6'd0, eSel});
    chk({name, ".owner"}, {7'd0, owner}, {7'd0, eOwner});
  endtask

  task automatic pressAndWait(input string name, input logic [3:0] b, input int idx);
    bit seen = 0;
    expQ.push_back(idx);
    btn = b;
    for (int i = 0; i < 20 && !seen; i++) begin
      cyc(1);
      seen = player_pressed;
    end
    if (!seen) begin
      nCmp++;
      nBad++;
      $display("FAIL %s: no player_pressed within 20 cycles", name);
    end
  endtask

  // monitor: every accepted press must match the next scoreboard entry
  always @(negedge clk) begin
    if (player_pressed) begin
      nCmp++;
      if (expQ.size() == 0) begin
        nBad++;
        $display("FAIL unexpected_press: got player_num %0d expected no pulse", player_num);
      end else begin
        int e;
        e = expQ.pop_front();
        if (int'(player_num) != e) begin
          nBad++;
          $display("FAIL press_num: got %0d expected %0d", player_num, e);
        end
      end
      if (owner || prevPulse) begin
        nBad++;
        $display("FAIL press_rules: owner %0b prevPulse %0b expected 0 0", owner, prevPulse);
      end
    end
    prevPulse <= player_pressed;
  end

  initial begin
    cyc(3);
    panel("reset", 4'b0000, 1'b0, 2'd0, 1'b0);
    chk("reset.player", {5'd0, player_pressed, player_num}, 8'd0);
    reset = 1'b0;
    simon_turn = 1'b1; simon_num = 2'd2; simon_pressed = 1'b1;
    cyc(1);
    panel("simon_show", 4'b0100, 1'b1, 2'd2, 1'b1);
    simon_pressed = 1'b0;
    cyc(1);
    panel("simon_dark", 4'b0000, 1'b0, 2'd0, 1'b1);
    simon_turn = 1'b0;
    cyc(2);
    pressAndWait("press3", 4'b1000, 3);
    panel("echo3_first", 4'b1000, 1'b1, 2'd3, 1'b0);
    cyc(14);
    panel("echo3_last", 4'b1000, 1'b1, 2'd3, 1'b0);
    cyc(1);
    panel("echo3_done", 4'b0000, 1'b0, 2'd0, 1'b0);
    btn = '0;
    cyc(8);
    btn = 4'b0011;
    cyc(10);
    panel("multi", 4'b0000, 1'b0, 2'd0, 1'b0);
    btn = '0;
    cyc(8);
    pressAndWait("press0", 4'b0001, 0);
    panel("echo0", 4'b0001, 1'b1, 2'd0, 1'b0);
    btn = '0;
    cyc(25);
    simon_turn = 1'b1;
    btn = 4'b0010;
    cyc(8);
    simon_turn = 1'b0;
    cyc(10);
    panel("held_across", 4'b0000, 1'b0, 2'd0, 1'b0);
    btn = '0;
    cyc(8);
    pressAndWait("press1", 4'b0010, 1);
    btn = '0;
    cyc(25);
    btn = 4'b0100;
    cyc(2);
    btn = '0;
    cyc(10);
    panel("glitch", 4'b0000, 1'b0, 2'd0, 1'b0);
    pressAndWait("press2", 4'b0100, 2);
    cyc(5);
    panel("echo2_mid", 4'b0100, 1'b1, 2'd2, 1'b0);
    simon_turn = 1'b1; simon_num = 2'd1; simon_pressed = 1'b1;
    cyc(1);
    panel("preempt", 4'b0010, 1'b1, 2'd1, 1'b1);
    btn = '0; simon_turn = 1'b0; simon_pressed = 1'b0;
    cyc(10);
    game_over = 1'b1;
    cyc(1);
    panel("over_entry", 4'b1111, 1'b0, 2'd0, 1'b0);
    btn = 4'b0001;
    cyc(10);
    panel("over_k10", 4'b1111, 1'b0, 2'd0, 1'b0);
    btn = '0;
    cyc(10);
`ifdef SIMON_IO_OVER_FLASH_EN
    panel("over_k20", 4'b0000, 1'b0, 2'd0, 1'b0);
`else
    panel("over_k20", 4'b1111, 1'b0, 2'd0, 1'b0);
`endif
    game_over = 1'b0; simon_turn = 1'b1; simon_pressed = 1'b1;
    cyc(20);
    panel("over_k40", 4'b1111, 1'b0, 2'd0, 1'b0);
    reset = 1'b1;
    cyc(1);
    panel("reset_again", 4'b0000, 1'b0, 2'd0, 1'b0);
    chk("reset_again.player", {5'd0, player_pressed, player_num}, 8'd0);
    chk("scoreboard_empty", 8'(expQ.size()), 8'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
    $finish;
  end
endmodule
